// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: next-PC select encodings,
// the nop word, the default reset PC and the branch offset helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Sign-extended 16-bit word offset, scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection. A redirect is only honoured when the
// instruction in IF/ID is real; otherwise fetch continues sequentially.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] id_pc_i,
    input  logic        id_valid_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        br_take_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] iind_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] npc_o,
    output logic        redirect_o
);

    logic [31:0] seq_pc;
    logic [31:0] id_pc4;

    assign seq_pc = pc_i + 32'd4;
    assign id_pc4 = id_pc_i + 32'd4;

    // Pick the redirect target for the ID instruction, else PC+4.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        npc_o      = seq_pc;
        redirect_o = 1'b0;
        if (id_valid_i) begin
            case (npc_sel_e'(npc_sel_i))
                NPC_BR: begin
                    if (br_take_i) begin
                        npc_o      = id_pc4 + branch_offset(imm_i);
                        redirect_o = 1'b1;
                    end
                end
                NPC_J: begin
                    npc_o      = {id_pc4[31:28], iind_i, 2'b00};
                    redirect_o = 1'b1;
                end
                NPC_JR: begin
                    npc_o      = jr_target_i & ~32'h0000_0003;
                    redirect_o = 1'b1;
                end
                default: begin
                    npc_o      = seq_pc;
                    redirect_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// redirect handling. Define BRANCH_DELAY_SLOT_EN to let the instruction
// fetched in a redirect cycle (the delay slot) proceed; otherwise it is
// squashed to an invalid nop.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_take,
    input  logic [15:0] imm,
    input  logic [25:0] iind,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_ins_q, id_ins_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] npc;
    logic        redirect;

    npc_calc u_npc_calc (
        .pc_i        (pc_q),
        .id_pc_i     (id_pc_q),
        .id_valid_i  (id_valid_q),
        .npc_sel_i   (npc_sel),
        .br_take_i   (br_take),
        .imm_i       (imm),
        .iind_i      (iind),
        .jr_target_i (jr_target),
        .npc_o       (npc),
        .redirect_o  (redirect)
    );

    // Next-state for PC and IF/ID: hold on stall, squash on redirect.
    always_comb begin
        pc_d       = pc_q;
        id_ins_d   = id_ins_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        if (!stall) begin
            pc_d    = npc;
            id_pc_d = pc_q;
            if (redirect && !DELAY_SLOT) begin
                id_ins_d   = NOP;
                id_valid_d = 1'b0;
            end else begin
                id_ins_d   = imem_rdata;
                id_valid_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            pc_q       <= RESET_PC_W;
            id_ins_q   <= NOP;
            id_pc_q    <= RESET_PC_W;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_ins_q   <= id_ins_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_ins    = id_ins_q;
    assign id_pc     = id_pc_q;
    assign id_pc8    = id_pc_q + 32'd8;
    assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Observed state is packed as
// {pc, id_pc, id_valid, id_ins} and compared against hand-derived values.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic DS = 1'b1;
`else
    localparam logic DS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_take;
    logic [15:0] imm;
    logic [25:0] iind;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;

    int total = 0;
    int bad   = 0;

    logic [96:0] got;
    logic [96:0] exp;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .br_take    (br_take),
        .imm        (imm),
        .iind       (iind),
        .jr_target  (jr_target),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_ins     (id_ins),
        .id_pc      (id_pc),
        .id_pc8     (id_pc8),
        .id_valid   (id_valid)
    );

    // Instruction memory model: a recognisable word per address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = word(imem_addr);
    assign got = {imem_addr, id_pc, id_valid, id_ins};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_seq();
        stall     = 1'b0;
        npc_sel   = NPC_SEQ;
        br_take   = 1'b0;
        imm       = 16'h0;
        iind      = 26'h0;
        jr_target = 32'h0;
    endtask

    task automatic restart();
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        drive_seq();
    endtask

    task automatic test_reset();
        drive_seq();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        // mid-run asynchronous reset, sampled well before the next edge
        reset = 1'b1;
        #1;
        exp = {32'h3000, 32'h3000, 1'b0, 32'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL reset_async got=%h want=%h", got, exp); end
        total++; if (id_pc8 !== 32'h3008) begin bad++; $display("FAIL reset_pc8 got=%h want=%h", id_pc8, 32'h3008); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {32'h3004 + 32'(4 * i), 32'h3000 + 32'(4 * i), 1'b1, word(32'h3000 + 32'(4 * i))};
            total++; if (got !== exp) begin bad++; $display("FAIL reset_step%0d got=%h want=%h", i, got, exp); end
        end
    endtask

    task automatic test_branch();
        restart();
        repeat (3) tick();
        npc_sel = NPC_BR; br_take = 1'b1; imm = 16'hFFFE;
        tick();
        exp = {32'h3004, 32'h300C, DS, DS ? word(32'h300C) : 32'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL br_back got=%h want=%h", got, exp); end
        // jump issued while IF/ID holds the slot: ignored when squashed
        npc_sel = NPC_J; iind = 26'h3FF_FFFF;
        tick();
        exp = {DS ? 32'h0FFF_FFFC : 32'h3008, 32'h3004, 1'b1, word(32'h3004)};
        total++; if (got !== exp) begin bad++; $display("FAIL br_slot_jump got=%h want=%h", got, exp); end
        // not-taken branch
        restart();
        repeat (2) tick();
        npc_sel = NPC_BR; br_take = 1'b0; imm = 16'hFFFE;
        tick();
        exp = {32'h300C, 32'h3008, 1'b1, word(32'h3008)};
        total++; if (got !== exp) begin bad++; $display("FAIL br_not_taken got=%h want=%h", got, exp); end
    endtask

    task automatic test_jump();
        restart();
        repeat (5) tick();
        exp = {32'h3014, 32'h3010, 1'b1, word(32'h3010)};
        total++; if (got !== exp) begin bad++; $display("FAIL j_setup got=%h want=%h", got, exp); end
        npc_sel = NPC_J; iind = 26'h000_0C10;
        tick();
        exp = {32'h3040, 32'h3014, DS, DS ? word(32'h3014) : 32'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL j_target got=%h want=%h", got, exp); end
        drive_seq();
        tick();
        exp = {32'h3044, 32'h3040, 1'b1, word(32'h3040)};
        total++; if (got !== exp) begin bad++; $display("FAIL j_follow got=%h want=%h", got, exp); end
        npc_sel = NPC_JR; jr_target = 32'h0000_3007;
        tick();
        exp = {32'h3004, 32'h3044, DS, DS ? word(32'h3044) : 32'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL jr_target got=%h want=%h", got, exp); end
        // wrap of PC+4 and id_pc+8 at the top of the address space
        drive_seq();
        tick();
        npc_sel = NPC_JR; jr_target = 32'hFFFF_FFFF;
        tick();
        exp = {32'hFFFF_FFFC, 32'h3008, DS, DS ? word(32'h3008) : 32'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL jr_high got=%h want=%h", got, exp); end
        drive_seq();
        tick();
        exp = {32'h0, 32'hFFFF_FFFC, 1'b1, word(32'hFFFF_FFFC)};
        total++; if (got !== exp) begin bad++; $display("FAIL pc_wrap got=%h want=%h", got, exp); end
        total++; if (id_pc8 !== 32'h4) begin bad++; $display("FAIL pc8_wrap got=%h want=%h", id_pc8, 32'h4); end
        npc_sel = NPC_BR; br_take = 1'b1; imm = 16'h0001;
        tick();
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL br_wrap got=%h want=%h", imem_addr, 32'h4); end
    endtask

    task automatic test_stall();
        restart();
        repeat (3) tick();
        stall = 1'b1; npc_sel = NPC_J; iind = 26'h000_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {32'h300C, 32'h3008, 1'b1, word(32'h3008)};
            total++; if (got !== exp) begin bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, got, exp); end
        end
        stall = 1'b0;
        tick();
        exp = {32'h0400, 32'h300C, DS, DS ? word(32'h300C) : 32'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL stall_release got=%h want=%h", got, exp); end
        drive_seq();
        tick();
        exp = {32'h0404, 32'h0400, 1'b1, word(32'h0400)};
        total++; if (got !== exp) begin bad++; $display("FAIL stall_once got=%h want=%h", got, exp); end
        // reset while a stalled redirect is pending discards it
        stall = 1'b1; npc_sel = NPC_J; iind = 26'h000_0200;
        reset = 1'b1;
        #1;
        exp = {32'h3000, 32'h3000, 1'b0, 32'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL stall_reset got=%h want=%h", got, exp); end
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        tick();
        exp = {32'h3004, 32'h3000, 1'b1, word(32'h3000)};
        total++; if (got !== exp) begin bad++; $display("FAIL stall_reset_fetch got=%h want=%h", got, exp); end
    endtask

    initial begin
        reset = 1'b1;
        drive_seq();
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
